// File: rtl/fp_add_arbiter4.sv
// Four requesters share one combinational FP32 add/sub through a round-robin grant.
// Accept to res_valid is two cycles; the result holds in RESULT until res_ready, so one op per 3 cycles at best.
module fp_add_arbiter4 #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_zero,
    output logic [1:0]            res_id,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [1:0]       op_id_q, op_id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic [1:0]       res_id_q, res_id_d;
    logic [15:0]      op_count_q, op_count_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic [WIDTH-1:0] a_sel, b_sel;

    // Shared adder datapath
    logic             a_big;
    logic [31:0]      big_w, sml_w;
    logic [7:0]       e_big, e_sml, e_diff;
    logic [23:0]      m_big, m_sml, m_sml_sh;
    logic [24:0]      sum;
    logic [4:0]       lz;
    logic             lz_found;
    logic [22:0]      norm_frac;
    logic [31:0]      add_res;
    logic             add_zero;

    // Round-robin search starting one past the last accepted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand = last_grant_q + 2'd1 + 2'(i);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Align, add/sub magnitudes, normalise and truncate; no rounding or special values
    always_comb begin
        a_big    = (op_a_q[30:0] >= op_b_q[30:0]);
        big_w    = a_big ? op_a_q : op_b_q;
        sml_w    = a_big ? op_b_q : op_a_q;
        e_big    = big_w[30:23];
        e_sml    = sml_w[30:23];
        m_big    = {|e_big, big_w[22:0]};
        m_sml    = {|e_sml, sml_w[22:0]};
        e_diff   = e_big - e_sml;
        m_sml_sh = (e_diff > 8'd24) ? 24'd0 : (m_sml >> e_diff);
        if (big_w[31] == sml_w[31]) begin
            sum = {1'b0, m_big} + {1'b0, m_sml_sh};
        end else begin
            sum = {1'b0, m_big} - {1'b0, m_sml_sh};
        end
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 5'd1;
                end
            end
        end
        norm_frac = sum[22:0] << lz;
        add_zero  = (sum == 25'd0);
        if (add_zero) begin
            add_res = '0;
        end else if (sum[24]) begin
            add_res = {big_w[31], e_big + 8'd1, sum[23:1]};
        end else if ({3'd0, lz} >= e_big) begin
            add_res = '0;
        end else begin
            add_res = {big_w[31], e_big - {3'd0, lz}, norm_frac};
        end
    end

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        res_id_d     = res_id_q;
        op_count_d   = op_count_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    op_a_d             = a_sel;
                    op_b_d             = {b_sel[WIDTH-1] ^ req_sub[gnt_idx], b_sel[WIDTH-2:0]};
                    op_id_d            = gnt_idx;
                    last_grant_d       = gnt_idx;
                    state_d            = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d = add_res;
                res_zero_d = add_zero;
                res_id_d   = op_id_q;
                state_d    = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= 2'd0;
            res_data_q   <= '0;
            res_zero_q   <= 1'b0;
            res_id_q     <= 2'd0;
            op_count_q   <= 16'd0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            res_id_q     <= res_id_d;
            op_count_q   <= op_count_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_id    = res_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter4.sv
// Directed bench for fp_add_arbiter4: vector table plus arbitration, stall, reset and wrap sequences.
module tb_fp_add_arbiter4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_sub;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_data;
    logic         res_zero;
    logic [1:0]   res_id;
    logic [15:0]  op_count;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [15:0]  exp_cnt;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] data;
        logic        zero;
    } vec_t;

    vec_t        vecs[7];
    int          rr_order[6];
    logic [31:0] rr_res[4];

    always #5 clk = ~clk;

    fp_add_arbiter4 #(.NREQ(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_sub[id]        = s;
    endtask

    // Starts in an IDLE cycle; ends in the IDLE cycle after the result handshake.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] ed, input logic ez);
        set_req(id, a, b, s);
        req_valid = 4'(1 << id);
        res_ready = 1'b1;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(1 << id));
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        tick();
        req_valid = 4'hF;
        req_a     = {4{32'hDEADBEEF}};
        req_b     = {4{32'h12345678}};
        req_sub   = 4'hF;
        #1;
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_res_valid", 32'(res_valid), 32'd0);
        tick();
        req_valid = 4'h0;
        chk("result_valid", 32'(res_valid), 32'd1);
        chk("result_data", res_data, ed);
        chk("result_zero", 32'(res_zero), 32'(ez));
        chk("result_id", 32'(res_id), 32'(id));
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("post_valid", 32'(res_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0};
        vecs[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
        vecs[2] = '{2, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1};
        vecs[3] = '{1, 32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 1'b0};
        vecs[4] = '{3, 32'hC0000000, 32'h3F000000, 1'b0, 32'hBFC00000, 1'b0};
        vecs[5] = '{0, 32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 1'b0};
        vecs[6] = '{1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
        rr_order = '{0, 1, 2, 3, 0, 1};
        rr_res   = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        res_ready = 1'b0;
        exp_cnt   = 16'd0;

        // Reset: no ready even with every requester asking
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_ready2", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_zero", 32'(res_zero), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        req_valid = 4'h0;
        rst_n     = 1'b1;

        // Round-robin with all four requesters held valid
        tick();
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
        set_req(1, 32'h40000000, 32'h3F800000, 1'b0);
        set_req(2, 32'h40400000, 32'h3F800000, 1'b0);
        set_req(3, 32'h40800000, 32'h3F800000, 1'b0);
        res_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << rr_order[k]));
            tick();
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            tick();
            chk("rr_valid", 32'(res_valid), 32'd1);
            chk("rr_id", 32'(res_id), 32'(rr_order[k]));
            chk("rr_data", res_data, rr_res[rr_order[k]]);
            tick();
            exp_cnt = exp_cnt + 16'd1;
        end
        req_valid = 4'h0;
        #1;
        chk("rr_op_count", 32'(op_count), 32'(exp_cnt));

        // Table of arithmetic vectors
        for (int v = 0; v < 7; v++) begin
            run_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].data, vecs[v].zero);
        end

        // res_ready with nothing pending is ignored
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_rdy_valid", 32'(res_valid), 32'd0);
            chk("idle_rdy_count", 32'(op_count), 32'(exp_cnt));
        end

        // Backpressure: 4.0 - 1.0 held in RESULT
        set_req(2, 32'h40800000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100;
        res_ready = 1'b0;
        #1;
        chk("bp_accept", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'h0;
        tick();
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'hF;
            #1;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", res_data, 32'h40400000);
            chk("bp_id", 32'(res_id), 32'd2);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_count", 32'(op_count), 32'(exp_cnt));
            tick();
        end
        req_valid = 4'h0;
        res_ready = 1'b1;
        chk("bp_last_valid", 32'(res_valid), 32'd1);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_count", 32'(op_count), 32'(exp_cnt));

        // Reset during EXEC drops the op and restores priority to requester 0
        set_req(1, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'h0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_count", 32'(op_count), 32'd0);
        chk("midrst_data", res_data, 32'd0);
        chk("midrst_id", 32'(res_id), 32'd0);
        chk("midrst_zero", 32'(res_zero), 32'd0);
        tick();
        chk("midrst_no_result", 32'(res_valid), 32'd0);
        exp_cnt = 16'd0;
        set_req(0, 32'h40000000, 32'h40000000, 1'b0);
        set_req(3, 32'h3F800000, 32'h3F800000, 1'b0);
        req_valid = 4'b1001;
        #1;
        chk("midrst_grant0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        tick();
        chk("midrst_res_id", 32'(res_id), 32'd0);
        chk("midrst_res_data", res_data, 32'h40800000);
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("midrst_count1", 32'(op_count), 32'(exp_cnt));

        // Counter wrap from 0xFFFF
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        chk("wrap_preload", 32'(op_count), 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        run_op(3, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
        chk("wrap_zero", 32'(op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter4.md
FP_ADD_ARBITER4 -- requirements
Module: fp_add_arbiter4

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL have parameter WIDTH, default 32, IEEE-754 single-precision operand width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 4, per-requester operation request.
REQ-006 SHALL have port req_ready, output, 4, per-requester accept strobe (one-hot or zero).
REQ-007 SHALL have port req_a, input, 128, operand A; requester i in bits [32i+31:32i].
REQ-008 SHALL have port req_b, input, 128, operand B; same packing as req_a.
REQ-009 SHALL have port req_sub, input, 4, per-requester mode; 1 = A-B, 0 = A+B.
REQ-010 SHALL have port res_valid, output, 1, result available.
REQ-011 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port res_data, output, 32, FP32 result.
REQ-013 SHALL have port res_zero, output, 1, result mantissa sum was zero (adder zero flag).
REQ-014 SHALL have port res_id, output, 2, index of requester that owns res_data.
REQ-015 SHALL have port op_count, output, 16, number of completed result handshakes, wraps 0xFFFF->0x0000.

Function
REQ-016 SHALL share one internal combinational FP32 adder/subtractor (the team's existing FP32 add/sub core) among the 4 requesters.
REQ-017 SHALL implement FSM states IDLE, EXEC, RESULT; reset state IDLE.
REQ-018 IDLE: if any req_valid set, SHALL grant exactly one requester and assert its req_ready combinationally in that cycle; handshake completes at the clock edge; next state EXEC; else stay IDLE.
REQ-019 req_ready SHALL be zero in EXEC and RESULT, and zero in IDLE when req_valid is zero.
REQ-020 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4; last_grant updates only on an accepted handshake; after reset last_grant=3 (requester 0 highest priority).
REQ-021 On accept SHALL latch A, B (with B sign bit inverted when req_sub of the granted requester is 1) and granted index into operand registers.
REQ-022 EXEC: adder evaluates latched operands; at the edge SHALL register adder output into res_data, zero flag into res_zero, index into res_id; next state RESULT.
REQ-023 RESULT: res_valid SHALL be 1; res_data/res_zero/res_id SHALL be stable until res_ready=1 at a clock edge; then state IDLE, res_valid 0 next cycle, op_count +1.
REQ-024 Latency: request accepted at edge of cycle k -> res_valid high in cycle k+2; minimum throughput one operation per 3 cycles.
REQ-025 A requester deasserting req_valid before its req_ready SHALL cause no operation and no pointer update.
REQ-026 Request inputs changing while in EXEC or RESULT SHALL NOT affect the in-flight result.
REQ-027 res_ready asserted while res_valid=0 SHALL be ignored (no count, no state change).
REQ-028 Arithmetic: no rounding or special-value (NaN/Inf/denormal) handling beyond the shared core; outputs are exactly the core's result for the latched operands.

Reset
REQ-029 With rst_n=0 at a clock edge, SHALL set state IDLE, res_valid 0, res_data 0, res_zero 0, res_id 0, op_count 0, last_grant 3, operand registers 0.
REQ-030 Reset in EXEC or RESULT SHALL discard the in-flight operation; no result handshake and no op_count increment for it.
REQ-031 req_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 Add: req0 A=0x3F800000 (1.0), B=0x40000000 (2.0), sub=0, res_ready=1 -> req_ready[0] in cycle 0, res_valid cycle 2, res_data=0x40400000, res_id=0, op_count=1.
REQ-033 Subtract/zero: req2 A=0x40400000, B=0x3F800000, sub=1 -> res_data=0x40000000; then A=B=0x3F800000, sub=1 -> res_zero=1.
REQ-034 Round-robin: all four req_valid held high, res_ready=1 -> grant order 0,1,2,3,0,1; accepts every 3 cycles; res_id matches order.
REQ-035 Backpressure: res_ready=0 for 5 cycles in RESULT -> res_valid, res_data, res_id stable, req_ready=0 throughout; op_count increments once after res_ready=1.
REQ-036 Reset mid-op: rst_n=0 one cycle during EXEC -> next cycle res_valid=0, op_count=0, outputs 0; next request from requester 3 alongside 0 grants 0 first.
REQ-037 Wrap: preload via 65535 completed ops (or force) -> next handshake gives op_count=0x0000.
